naive_bus_arbiter_2m: RTL and testbench
=======================================

Name: naive_bus_arbiter_2m

Overview:
- Shares one naive_bus slave path between two masters: m0 is the CPU data port and m1 is the ISP debug master.
- Sits between the masters and the bus decoder. The ISP can then peek and poke SoC memory while the core runs.
- Registered ownership FSM with round-robin or fixed priority. Read data is routed back to the master whose read was granted.

Parameters:
- PRIORITY_MODE, 0: 0 = round-robin between m0/m1; 1 = fixed priority, m0 wins.
- HOLD_MAX, 255: max cycles an owner may wait for slave gnt before a stall flag is raised; must be 1..255.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- m0  naive_bus.slave  -  CPU master port
- m1  naive_bus.slave  -  ISP master port
- s  naive_bus.master  -  downstream slave port
- o_owner  out  2  current owner: 0 none, 1 m0, 2 m1
- o_stall  out  1  sticky: owner waited more than HOLD_MAX cycles

Behaviour:
- naive_bus rules:
  - a master holds req/addr/data/be stable until it sees gnt in the same cycle;
  - rd_data is valid exactly one cycle after rd_req&rd_gnt.
- A request from master x is rd_req|wr_req.
- FSM states: IDLE, OWN0, OWN1. State and op are registered. op = RD if owner's rd_req else WR; read wins when both are asserted.
- IDLE:
  - no request -> stay;
  - one requester -> OWNx next edge;
  - both: PRIORITY_MODE=1 -> OWN0; PRIORITY_MODE=0 -> the master not equal to last_gnt.
- OWNx forwarding:
  - s.rd_req = (op==RD)&mx.rd_req; s.wr_req = (op==WR)&mx.wr_req;
  - addr/data/be forwarded combinationally from mx;
  - mx.rd_gnt = s.rd_gnt&(op==RD); mx.wr_gnt = s.wr_gnt&(op==WR);
  - the non-owner sees gnt=0.
- On the forwarded req & gnt edge: last_gnt<=x and next state IDLE. The bubble is intentional, so back-to-back grants are at most 1 per 2 cycles.
- OWNx with the owner's request dropped (protocol violation) -> IDLE next edge; nothing is forwarded that cycle.
- Latency: request at cycle N (arbiter in IDLE) -> forwarded to s at N+1. The earliest gnt seen by the master is N+1.
- Read return: rd_sel<=x on a read grant edge, else rd_sel<=none.
  - mx.rd_data = s.rd_data when rd_sel==x, else 32'h0.
  - The non-selected master always sees 0.
- Idle outputs: all s.*_req=0 and s addr/data/be=0 when state is IDLE.
- Hold counter:
  - cleared on entering OWNx; increments each OWNx cycle without gnt; saturates at 255;
  - hold_cnt==HOLD_MAX with no gnt -> o_stall<=1 (sticky until rst).
  - The request is never aborted.
- Reset (sync, rst=1 at posedge): state=IDLE, last_gnt=m1 (so m0 wins the first tie), rd_sel=none, hold_cnt=0, o_stall=0, o_owner=0.
  - Reset mid-transaction drops the forwarded req the next cycle. A pending rd_data is not routed.
- Simultaneous: a grant and a new request from the other master in the same cycle -> the other master is selected from IDLE on the following edge. A starved master waits at most one foreign transaction in round-robin mode.

Test Plan:
- Single read m1 addr 0x0000_1000, slave gnt immediately, rd_data 0xDEADBEEF:
  - m1.rd_gnt at cycle N+1;
  - m1.rd_data=0xDEADBEEF at N+2;
  - m0.rd_data=0 throughout.
- m0 and m1 both issue writes at the same cycle, PRIORITY_MODE=0, after reset:
  - m0 is granted first, then m1 two cycles later;
  - repeating the tie alternates m1, then m0.
- PRIORITY_MODE=1, m0 streams 4 reads while m1 holds a write of 0x12345678 to 0x2000:
  - m1 is granted only after m0 drops its request;
  - s.wr_data=0x12345678 on m1's grant cycle.
- m0 asserts rd_req and wr_req together at addr 0x10:
  - the read is forwarded first (s.rd_req=1, s.wr_req=0);
  - the write is forwarded after the read is granted plus the IDLE bubble.
- Slave withholds gnt for 300 cycles, HOLD_MAX=255:
  - o_stall rises at wait cycle 255 and stays 1 after gnt;
  - it clears only on rst.
- rst asserted the cycle after a read grant to m0:
  - o_owner=0 and s.rd_req=0 next cycle;
  - m0.rd_data=0 (return suppressed).

Source files
------------

// File: rtl/naive_bus_arbiter_2m_if.sv
// naive_bus: simple request/grant memory bus with single-cycle read return.
// The master holds req/addr/data/be until it sees the matching gnt, and
// rd_data is valid one cycle after rd_req & rd_gnt.
interface naive_bus;
    logic        rd_req;
    logic        wr_req;
    logic        rd_gnt;
    logic        wr_gnt;
    logic [31:0] addr;
    logic [31:0] wr_data;
    logic [31:0] rd_data;
    logic [3:0]  be;

    modport master (
        output rd_req, wr_req, addr, wr_data, be,
        input  rd_gnt, wr_gnt, rd_data
    );

    modport slave (
        input  rd_req, wr_req, addr, wr_data, be,
        output rd_gnt, wr_gnt, rd_data
    );
endinterface

// File: rtl/naive_bus_arbiter_2m.sv
// Two-master naive_bus arbiter: the CPU data port (m0) and the ISP debug
// master (m1) share one downstream slave path. Ownership is registered, so a
// request seen in IDLE is forwarded on the following cycle, and every
// transfer is followed by one IDLE bubble before the next owner is chosen.
module naive_bus_arbiter_2m #(
    parameter int PRIORITY_MODE = 0,
    parameter int HOLD_MAX      = 255
) (
    input  logic       clk,
    input  logic       rst,
    naive_bus.slave    m0,
    naive_bus.slave    m1,
    naive_bus.master   s,
    output logic [1:0] o_owner,
    output logic       o_stall
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    typedef enum logic {
        OP_RD = 1'b0,
        OP_WR = 1'b1
    } op_t;

    localparam logic [1:0] SEL_NONE   = 2'd0;
    localparam logic [1:0] SEL_M0     = 2'd1;
    localparam logic [1:0] SEL_M1     = 2'd2;
    localparam logic [7:0] HOLD_LIMIT = 8'(HOLD_MAX);

    state_t      state, state_nxt;
    op_t         op, op_nxt;
    logic        last_gnt, last_gnt_nxt;
    logic [1:0]  rd_sel, rd_sel_nxt;
    logic [7:0]  hold_cnt;
    logic        req0, req1;
    logic        own_rd, own_wr;
    logic        fwd_rd, fwd_wr, fwd_req, xfer;
    logic        pick;

    assign req0    = m0.rd_req | m0.wr_req;
    assign req1    = m1.rd_req | m1.wr_req;
    assign o_owner = state;

    // Select the current owner's request lines and qualify them with the latched op.
    always_comb begin
        own_rd = 1'b0;
        own_wr = 1'b0;
        case (state)
            OWN0: begin
                own_rd = m0.rd_req;
                own_wr = m0.wr_req;
            end
            OWN1: begin
                own_rd = m1.rd_req;
                own_wr = m1.wr_req;
            end
            default: ;
        endcase
        fwd_rd  = (op == OP_RD) & own_rd;
        fwd_wr  = (op == OP_WR) & own_wr;
        fwd_req = fwd_rd | fwd_wr;
        xfer    = (fwd_rd & s.rd_gnt) | (fwd_wr & s.wr_gnt);
    end

    // Forward the owner to the slave, return grants to it, and route read data.
    always_comb begin
        s.rd_req   = fwd_rd;
        s.wr_req   = fwd_wr;
        s.addr     = 32'h0;
        s.wr_data  = 32'h0;
        s.be       = 4'h0;
        m0.rd_gnt  = 1'b0;
        m0.wr_gnt  = 1'b0;
        m1.rd_gnt  = 1'b0;
        m1.wr_gnt  = 1'b0;
        if (state == OWN0) begin
            s.addr    = m0.addr;
            s.wr_data = m0.wr_data;
            s.be      = m0.be;
            m0.rd_gnt = fwd_rd & s.rd_gnt;
            m0.wr_gnt = fwd_wr & s.wr_gnt;
        end else if (state == OWN1) begin
            s.addr    = m1.addr;
            s.wr_data = m1.wr_data;
            s.be      = m1.be;
            m1.rd_gnt = fwd_rd & s.rd_gnt;
            m1.wr_gnt = fwd_wr & s.wr_gnt;
        end
        m0.rd_data = (rd_sel == SEL_M0 && !rst) ? s.rd_data : 32'h0;
        m1.rd_data = (rd_sel == SEL_M1 && !rst) ? s.rd_data : 32'h0;
    end

    // Choose the next owner from IDLE and release ownership after a transfer or a dropped request.
    always_comb begin
        state_nxt    = state;
        op_nxt       = op;
        last_gnt_nxt = last_gnt;
        rd_sel_nxt   = SEL_NONE;
        pick         = 1'b0;
        case (state)
            IDLE: begin
                if (req0 && req1) begin
                    pick = (PRIORITY_MODE != 0) ? 1'b0 : ~last_gnt;
                end else begin
                    pick = req1;
                end
                if (req0 || req1) begin
                    state_nxt = pick ? OWN1 : OWN0;
                    op_nxt    = (pick ? m1.rd_req : m0.rd_req) ? OP_RD : OP_WR;
                end
            end
            OWN0, OWN1: begin
                if (!fwd_req) begin
                    state_nxt = IDLE;
                end else if (xfer) begin
                    state_nxt    = IDLE;
                    last_gnt_nxt = (state == OWN1);
                    if (fwd_rd) begin
                        rd_sel_nxt = (state == OWN1) ? SEL_M1 : SEL_M0;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Ownership state, latched op, round-robin history and read-return select.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            op       <= OP_RD;
            last_gnt <= 1'b1;
            rd_sel   <= SEL_NONE;
        end else begin
            state    <= state_nxt;
            op       <= op_nxt;
            last_gnt <= last_gnt_nxt;
            rd_sel   <= rd_sel_nxt;
        end
    end

    // Count cycles an owner waits without a grant and raise a sticky stall flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_cnt <= 8'd0;
            o_stall  <= 1'b0;
        end else if (state == IDLE) begin
            hold_cnt <= 8'd0;
        end else if (!xfer) begin
            if (hold_cnt != 8'hFF) begin
                hold_cnt <= hold_cnt + 8'd1;
            end
            if (hold_cnt == HOLD_LIMIT) begin
                o_stall <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_naive_bus_arbiter_2m.sv
// Directed bench for naive_bus_arbiter_2m: a round-robin instance and a
// fixed-priority instance share clock and reset; the bench plays both masters
// and the slave, with hand-computed expectations at each step.
module tb_naive_bus_arbiter_2m;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] rr_owner, fp_owner;
    logic       rr_stall, fp_stall;
    int         tests_run    = 0;
    int         tests_failed = 0;

    naive_bus rr_m0 ();
    naive_bus rr_m1 ();
    naive_bus rr_s  ();
    naive_bus fp_m0 ();
    naive_bus fp_m1 ();
    naive_bus fp_s  ();

    naive_bus_arbiter_2m #(.PRIORITY_MODE(0), .HOLD_MAX(255)) dut_rr (
        .clk(clk), .rst(rst), .m0(rr_m0), .m1(rr_m1), .s(rr_s),
        .o_owner(rr_owner), .o_stall(rr_stall)
    );

    naive_bus_arbiter_2m #(.PRIORITY_MODE(1), .HOLD_MAX(255)) dut_fp (
        .clk(clk), .rst(rst), .m0(fp_m0), .m1(fp_m1), .s(fp_s),
        .o_owner(fp_owner), .o_stall(fp_stall)
    );

    // Free-running 10 ns clock.
    always #5 clk = ~clk;

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    // Drive both masters and the slave side of one arbiter instance, then let it settle.
    task automatic applyStimulus(
        input bit          fp,
        input logic        m0_rd, input logic m0_wr,
        input logic [31:0] m0_addr, input logic [31:0] m0_data,
        input logic        m1_rd, input logic m1_wr,
        input logic [31:0] m1_addr, input logic [31:0] m1_data,
        input logic        s_rdg, input logic s_wrg,
        input logic [31:0] s_rdata
    );
        if (fp) begin
            fp_m0.rd_req = m0_rd;  fp_m0.wr_req = m0_wr;
            fp_m0.addr = m0_addr;  fp_m0.wr_data = m0_data;
            fp_m0.be = (m0_rd | m0_wr) ? 4'hF : 4'h0;
            fp_m1.rd_req = m1_rd;  fp_m1.wr_req = m1_wr;
            fp_m1.addr = m1_addr;  fp_m1.wr_data = m1_data;
            fp_m1.be = (m1_rd | m1_wr) ? 4'hF : 4'h0;
            fp_s.rd_gnt = s_rdg;   fp_s.wr_gnt = s_wrg;
            fp_s.rd_data = s_rdata;
        end else begin
            rr_m0.rd_req = m0_rd;  rr_m0.wr_req = m0_wr;
            rr_m0.addr = m0_addr;  rr_m0.wr_data = m0_data;
            rr_m0.be = (m0_rd | m0_wr) ? 4'hF : 4'h0;
            rr_m1.rd_req = m1_rd;  rr_m1.wr_req = m1_wr;
            rr_m1.addr = m1_addr;  rr_m1.wr_data = m1_data;
            rr_m1.be = (m1_rd | m1_wr) ? 4'hF : 4'h0;
            rr_s.rd_gnt = s_rdg;   rr_s.wr_gnt = s_wrg;
            rr_s.rd_data = s_rdata;
        end
        #1;
    endtask

    // One comparison: count it, and on a difference count and report it.
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        tests_run++;
        assert (observed === expected) else begin
            tests_failed++;
            $error("[TB] FAIL %s: observed %h, expected %h", tag, observed, expected);
        end
    endtask

    // Synchronous reset of both instances with all buses idle.
    task automatic doReset();
        rst = 1'b1;
        applyStimulus(1'b0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(1'b1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        cycle();
        rst = 1'b0;
    endtask

    // Directed sequence covering reset, reads, ties, priority, split ops, stall and reset abort.
    initial begin
        doReset();
        cycle();
        checkOutput("reset_owner", 32'(rr_owner), 32'd0);
        checkOutput("reset_stall", 32'(rr_stall), 32'd0);
        checkOutput("reset_s_rd_req", 32'(rr_s.rd_req), 32'd0);
        checkOutput("reset_s_wr_req", 32'(rr_s.wr_req), 32'd0);
        checkOutput("reset_s_addr", rr_s.addr, 32'h0);
        checkOutput("reset_fp_owner", 32'(fp_owner), 32'd0);

        $display("[TB] single read from m1");
        cycle();
        applyStimulus(1'b0, 0, 0, 0, 0, 1, 0, 32'h0000_1000, 0, 1, 1, 0);
        checkOutput("rd1_n_owner", 32'(rr_owner), 32'd0);
        checkOutput("rd1_n_m1_gnt", 32'(rr_m1.rd_gnt), 32'd0);
        checkOutput("rd1_n_s_rd_req", 32'(rr_s.rd_req), 32'd0);
        cycle();
        applyStimulus(1'b0, 0, 0, 0, 0, 1, 0, 32'h0000_1000, 0, 1, 1, 0);
        checkOutput("rd1_n1_owner", 32'(rr_owner), 32'd2);
        checkOutput("rd1_n1_s_rd_req", 32'(rr_s.rd_req), 32'd1);
        checkOutput("rd1_n1_s_wr_req", 32'(rr_s.wr_req), 32'd0);
        checkOutput("rd1_n1_s_addr", rr_s.addr, 32'h0000_1000);
        checkOutput("rd1_n1_s_be", 32'(rr_s.be), 32'hF);
        checkOutput("rd1_n1_m1_gnt", 32'(rr_m1.rd_gnt), 32'd1);
        checkOutput("rd1_n1_m0_gnt", 32'(rr_m0.rd_gnt), 32'd0);
        checkOutput("rd1_n1_m0_data", rr_m0.rd_data, 32'h0);
        cycle();
        applyStimulus(1'b0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 32'hDEAD_BEEF);
        checkOutput("rd1_n2_m1_data", rr_m1.rd_data, 32'hDEAD_BEEF);
        checkOutput("rd1_n2_m0_data", rr_m0.rd_data, 32'h0);
        checkOutput("rd1_n2_owner", 32'(rr_owner), 32'd0);
        checkOutput("rd1_n2_idle_addr", rr_s.addr, 32'h0);
        cycle();
        applyStimulus(1'b0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 32'hDEAD_BEEF);
        checkOutput("rd1_n3_m1_data", rr_m1.rd_data, 32'h0);

        $display("[TB] round-robin write ties");
        doReset();
        cycle();
        applyStimulus(1'b0, 0, 1, 32'h100, 32'hA0, 0, 1, 32'h200, 32'hB1, 1, 1, 0);
        checkOutput("tie_n_owner", 32'(rr_owner), 32'd0);
        cycle();
        applyStimulus(1'b0, 0, 1, 32'h100, 32'hA0, 0, 1, 32'h200, 32'hB1, 1, 1, 0);
        checkOutput("tie1_owner", 32'(rr_owner), 32'd1);
        checkOutput("tie1_m0_gnt", 32'(rr_m0.wr_gnt), 32'd1);
        checkOutput("tie1_m1_gnt", 32'(rr_m1.wr_gnt), 32'd0);
        checkOutput("tie1_s_wr_data", rr_s.wr_data, 32'hA0);
        cycle();
        applyStimulus(1'b0, 0, 1, 32'h104, 32'hA2, 0, 1, 32'h200, 32'hB1, 1, 1, 0);
        checkOutput("tie2_bubble_owner", 32'(rr_owner), 32'd0);
        checkOutput("tie2_bubble_wr_req", 32'(rr_s.wr_req), 32'd0);
        cycle();
        applyStimulus(1'b0, 0, 1, 32'h104, 32'hA2, 0, 1, 32'h200, 32'hB1, 1, 1, 0);
        checkOutput("tie2_owner", 32'(rr_owner), 32'd2);
        checkOutput("tie2_m1_gnt", 32'(rr_m1.wr_gnt), 32'd1);
        checkOutput("tie2_m0_gnt", 32'(rr_m0.wr_gnt), 32'd0);
        checkOutput("tie2_s_addr", rr_s.addr, 32'h200);
        checkOutput("tie2_s_wr_data", rr_s.wr_data, 32'hB1);
        cycle();
        applyStimulus(1'b0, 0, 1, 32'h104, 32'hA2, 0, 0, 0, 0, 1, 1, 0);
        checkOutput("tie3_bubble_owner", 32'(rr_owner), 32'd0);
        cycle();
        applyStimulus(1'b0, 0, 1, 32'h104, 32'hA2, 0, 0, 0, 0, 1, 1, 0);
        checkOutput("tie3_owner", 32'(rr_owner), 32'd1);
        checkOutput("tie3_m0_gnt", 32'(rr_m0.wr_gnt), 32'd1);
        checkOutput("tie3_s_wr_data", rr_s.wr_data, 32'hA2);
        cycle();
        applyStimulus(1'b0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        $display("[TB] fixed priority, m0 streams reads while m1 waits");
        doReset();
        for (int i = 0; i < 4; i++) begin
            cycle();
            applyStimulus(1'b1, 1, 0, 32'h40 + 32'(4 * i), 0, 0, 1, 32'h2000, 32'h1234_5678, 1, 1, 0);
            checkOutput("fp_bubble_owner", 32'(fp_owner), 32'd0);
            cycle();
            applyStimulus(1'b1, 1, 0, 32'h40 + 32'(4 * i), 0, 0, 1, 32'h2000, 32'h1234_5678, 1, 1, 0);
            checkOutput("fp_rd_owner", 32'(fp_owner), 32'd1);
            checkOutput("fp_m0_rd_gnt", 32'(fp_m0.rd_gnt), 32'd1);
            checkOutput("fp_m1_wr_gnt_blocked", 32'(fp_m1.wr_gnt), 32'd0);
            checkOutput("fp_s_addr", fp_s.addr, 32'h40 + 32'(4 * i));
        end
        cycle();
        applyStimulus(1'b1, 0, 0, 0, 0, 0, 1, 32'h2000, 32'h1234_5678, 1, 1, 0);
        checkOutput("fp_final_bubble", 32'(fp_owner), 32'd0);
        checkOutput("fp_final_bubble_gnt", 32'(fp_m1.wr_gnt), 32'd0);
        cycle();
        applyStimulus(1'b1, 0, 0, 0, 0, 0, 1, 32'h2000, 32'h1234_5678, 1, 1, 0);
        checkOutput("fp_m1_owner", 32'(fp_owner), 32'd2);
        checkOutput("fp_m1_wr_gnt", 32'(fp_m1.wr_gnt), 32'd1);
        checkOutput("fp_m1_s_wr_data", fp_s.wr_data, 32'h1234_5678);
        checkOutput("fp_m1_s_addr", fp_s.addr, 32'h2000);
        cycle();
        applyStimulus(1'b1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        $display("[TB] simultaneous read and write from m0");
        doReset();
        cycle();
        applyStimulus(1'b0, 1, 1, 32'h10, 32'h55, 0, 0, 0, 0, 1, 1, 0);
        cycle();
        applyStimulus(1'b0, 1, 1, 32'h10, 32'h55, 0, 0, 0, 0, 1, 1, 0);
        checkOutput("rw_rd_first", 32'(rr_s.rd_req), 32'd1);
        checkOutput("rw_wr_held", 32'(rr_s.wr_req), 32'd0);
        checkOutput("rw_m0_rd_gnt", 32'(rr_m0.rd_gnt), 32'd1);
        checkOutput("rw_m0_wr_gnt0", 32'(rr_m0.wr_gnt), 32'd0);
        checkOutput("rw_s_addr", rr_s.addr, 32'h10);
        cycle();
        applyStimulus(1'b0, 0, 1, 32'h10, 32'h55, 0, 0, 0, 0, 1, 1, 32'h0BAD_F00D);
        checkOutput("rw_bubble_wr_req", 32'(rr_s.wr_req), 32'd0);
        checkOutput("rw_bubble_owner", 32'(rr_owner), 32'd0);
        checkOutput("rw_rd_data", rr_m0.rd_data, 32'h0BAD_F00D);
        cycle();
        applyStimulus(1'b0, 0, 1, 32'h10, 32'h55, 0, 0, 0, 0, 1, 1, 0);
        checkOutput("rw_wr_fwd", 32'(rr_s.wr_req), 32'd1);
        checkOutput("rw_wr_rd_req0", 32'(rr_s.rd_req), 32'd0);
        checkOutput("rw_m0_wr_gnt", 32'(rr_m0.wr_gnt), 32'd1);
        checkOutput("rw_s_wr_data", rr_s.wr_data, 32'h55);
        cycle();
        applyStimulus(1'b0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        $display("[TB] slave withholds grant for 300 cycles");
        doReset();
        cycle();
        applyStimulus(1'b0, 0, 1, 32'h300, 32'h77, 0, 0, 0, 0, 0, 0, 0);
        for (int k = 1; k <= 300; k++) begin
            cycle();
            applyStimulus(1'b0, 0, 1, 32'h300, 32'h77, 0, 0, 0, 0, 0, (k == 300), 0);
            if (k == 250) begin
                checkOutput("stall_early", 32'(rr_stall), 32'd0);
                checkOutput("stall_early_owner", 32'(rr_owner), 32'd1);
            end
            if (k == 260) begin
                checkOutput("stall_raised", 32'(rr_stall), 32'd1);
                checkOutput("stall_req_held", 32'(rr_s.wr_req), 32'd1);
            end
            if (k == 300) begin
                checkOutput("stall_late_gnt", 32'(rr_m0.wr_gnt), 32'd1);
            end
        end
        cycle();
        applyStimulus(1'b0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("stall_after_gnt_owner", 32'(rr_owner), 32'd0);
        checkOutput("stall_sticky", 32'(rr_stall), 32'd1);
        cycle();
        cycle();
        checkOutput("stall_sticky_idle", 32'(rr_stall), 32'd1);
        doReset();
        cycle();
        checkOutput("stall_cleared_by_rst", 32'(rr_stall), 32'd0);

        $display("[TB] reset right after a read grant to m0");
        cycle();
        applyStimulus(1'b0, 1, 0, 32'h80, 0, 0, 0, 0, 0, 1, 1, 0);
        cycle();
        applyStimulus(1'b0, 1, 0, 32'h80, 0, 0, 0, 0, 0, 1, 1, 0);
        checkOutput("rstx_m0_rd_gnt", 32'(rr_m0.rd_gnt), 32'd1);
        cycle();
        rst = 1'b1;
        applyStimulus(1'b0, 1, 0, 32'h84, 0, 0, 0, 0, 0, 1, 1, 32'hCAFE_F00D);
        checkOutput("rstx_rd_data_suppressed", rr_m0.rd_data, 32'h0);
        checkOutput("rstx_m1_rd_data", rr_m1.rd_data, 32'h0);
        cycle();
        rst = 1'b0;
        applyStimulus(1'b0, 1, 0, 32'h84, 0, 0, 0, 0, 0, 1, 1, 32'hCAFE_F00D);
        checkOutput("rstx_owner", 32'(rr_owner), 32'd0);
        checkOutput("rstx_s_rd_req", 32'(rr_s.rd_req), 32'd0);
        checkOutput("rstx_m0_rd_data", rr_m0.rd_data, 32'h0);
        cycle();
        applyStimulus(1'b0, 1, 0, 32'h84, 0, 0, 0, 0, 0, 1, 1, 0);
        checkOutput("rstx_resume_owner", 32'(rr_owner), 32'd1);
        checkOutput("rstx_resume_rd_req", 32'(rr_s.rd_req), 32'd1);
        checkOutput("rstx_resume_addr", rr_s.addr, 32'h84);
        cycle();
        applyStimulus(1'b0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
